prescaled_tick_gen: RTL and testbench
=====================================

Name: prescaled_tick_gen

Overview:
Downstream consumer of the prescaler register block. It takes the 28-bit `prescaller` value and divides `clk` by (prescaller+1), producing a one-cycle `tick` strobe that drives the LED/timer logic. Control, status, a tick counter and an interrupt are exposed on its own Avalon-MM slave, so software can start, stop and one-shot the divider and count the events.

Parameters:
- CNT_W, 28, width of the prescaller input and of the internal period counter
- TCNT_W, 32, width of the tick event counter (must be ≤32)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- avs_s0_address  in  2  register select
- avs_s0_read  in  1  read strobe
- avs_s0_write  in  1  write strobe
- avs_s0_readdata  out  32  read data
- avs_s0_writedata  in  32  write data
- prescaller  in  CNT_W  period value P from the prescaler register block
- tick  out  1  one-cycle strobe, every P+1 cycles while running
- irq  out  1  level interrupt = irq_pending & irq_en

Behaviour:
- Reset: clk is the single clock; reset_n is asynchronous, active-low.
  - On reset, these are 0: enable, oneshot, irq_en, irq_pending, cnt, period_q, tick_count, tick, irq.
- Register map (combinational read, zero latency; readdata = 0 when read is low; unused bits read 0):
  - addr 0 CTRL, R/W: bit0 enable, bit1 oneshot, bit2 irq_en.
  - addr 1 STATUS: bit0 running (= enable), RO; bit1 irq_pending, write-1-to-clear.
  - addr 2 TICK_COUNT, RO zero-extended. Any write clears it to 0.
  - addr 3 CUR_COUNT, RO: {0, cnt}.
- Start:
  - A CTRL write that takes enable 0→1 at edge E loads period_q <= prescaller and cnt <= 0.
  - A write that keeps enable at 1 does not restart cnt or reload period_q.
- Counting while enable=1, on each edge:
  - If cnt == period_q: cnt <= 0, tick <= 1, period_q <= prescaller (reload at wrap).
  - Otherwise: cnt <= cnt+1, tick <= 0.
- Tick timing:
  - tick is registered and glitch-free.
  - First tick is high after edge E+P+1, then every P+1 cycles.
  - P=0 gives tick high every cycle from E+1.
- Period changes: a prescaller change mid-period takes effect only at the next wrap. The current period completes with the old value.
- Stop: a CTRL write clearing enable forces cnt <= 0 and tick <= 0 on that edge; no further ticks.
- Oneshot=1: on the wrap edge, tick <= 1, enable <= 0, cnt <= 0. Exactly one tick, then idle.
- Write/wrap collision: if a CTRL write coincides with a wrap edge, the written enable value wins. A tick still pulses on that edge if enable was 1 before it.
- TICK_COUNT:
  - Increments on each edge that sets tick, wrapping from 2^TCNT_W−1 to 0.
  - A write to addr 2 on the same edge as an increment wins: result is 0.
- irq_pending:
  - Set on each edge that sets tick while irq_en=1.
  - W1C on STATUS bit1. If set and clear land on the same edge, set wins.
  - Clearing irq_en does not clear irq_pending; it only masks irq.
- Address 3 and STATUS bit0 writes are ignored.
- Reset asserted mid-operation: all state clears immediately (asynchronous); tick and irq drop without waiting for clk.

Test Plan:
- Periodic run: prescaller=3, write CTRL=0x1 at edge E → tick high after E+4, E+8, E+12. TICK_COUNT reads 3 after E+12; CUR_COUNT cycles 0,1,2,3.
- P=0: prescaller=0, enable → tick high every cycle from E+1; TICK_COUNT increments by 1 each cycle.
- Mid-period change: prescaller=9, enable, change to 2 at cnt=4 → first tick after E+10, next ticks every 3 cycles.
- Oneshot with IRQ: CTRL=0x7, prescaller=5 → single tick after E+6 and irq=1. STATUS reads 0x2 (running=0). Write STATUS=0x2 → irq=0; no further ticks.
- Collisions:
  - TICK_COUNT clear on a tick edge → reads 0.
  - W1C of irq_pending on a tick edge with irq_en=1 → irq_pending stays 1.
  - TICK_COUNT forced to 0xFFFFFFFF via a long run (or by force) → wraps to 0 on the next tick.
- Async reset: assert reset_n=0 between edges while running with irq=1 → tick, irq, CUR_COUNT and CTRL read 0 immediately. No tick until enable is re-written after release.

Source files
------------

// File: rtl/prescaled_tick_gen.sv
// Divides clk by (prescaller+1) into a one-cycle tick strobe,
// with an Avalon-MM slave for control, status, tick count and irq.
module prescaled_tick_gen #(
  parameter int CNT_W  = 28,
  parameter int TCNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       avs_s0_address,
  input  logic             avs_s0_read,
  input  logic             avs_s0_write,
  output logic [31:0]      avs_s0_readdata,
  input  logic [31:0]      avs_s0_writedata,
  input  logic [CNT_W-1:0] prescaller,
  output logic             tick,
  output logic             irq
);

  logic              enable;
  logic              oneshot;
  logic              irq_en;
  logic              irq_pending;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  period_q;
  logic [TCNT_W-1:0] tick_count;

  logic wr_ctrl;
  logic wr_stat;
  logic wr_tcnt;
  logic wrap;
  logic en_next;
  logic start;
  logic unused_wdata;

  assign wr_ctrl = avs_s0_write && (avs_s0_address == 2'd0);
  assign wr_stat = avs_s0_write && (avs_s0_address == 2'd1);
  assign wr_tcnt = avs_s0_write && (avs_s0_address == 2'd2);

  assign wrap = enable && (cnt == period_q);

  // A written enable always beats the oneshot auto-stop on a wrap edge.
  assign en_next = wr_ctrl ? avs_s0_writedata[0]
                           : (enable && !(wrap && oneshot));
  assign start   = !enable && en_next;

  assign unused_wdata = ^avs_s0_writedata[31:3];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable      <= 1'b0;
      oneshot     <= 1'b0;
      irq_en      <= 1'b0;
      irq_pending <= 1'b0;
      cnt         <= '0;
      period_q    <= '0;
      tick_count  <= '0;
      tick        <= 1'b0;
    end else begin
      enable <= en_next;
      tick   <= wrap;
      if (wr_ctrl) begin
        oneshot <= avs_s0_writedata[1];
        irq_en  <= avs_s0_writedata[2];
      end
      if (start || wrap) begin
        cnt      <= '0;
        period_q <= prescaller;
      end else if (!en_next) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (wr_tcnt) begin
        tick_count <= '0;
      end else if (wrap) begin
        tick_count <= tick_count + TCNT_W'(1);
      end
      // Set beats a same-edge W1C so no event is lost.
      if (wrap && irq_en) begin
        irq_pending <= 1'b1;
      end else if (wr_stat && avs_s0_writedata[1]) begin
        irq_pending <= 1'b0;
      end
    end
  end

  assign irq = irq_pending & irq_en;

  always_comb begin
    avs_s0_readdata = '0;
    if (avs_s0_read) begin
      unique case (avs_s0_address)
        2'd0: avs_s0_readdata = {29'd0, irq_en, oneshot, enable};
        2'd1: avs_s0_readdata = {30'd0, irq_pending, enable};
        2'd2: avs_s0_readdata = 32'(tick_count);
        2'd3: avs_s0_readdata = 32'(cnt);
      endcase
    end
  end

endmodule

// File: tb/tb_prescaled_tick_gen.sv
// Randomized scoreboard bench for prescaled_tick_gen against an
// event-time reference model (next tick time, period start time).
module tb_prescaled_tick_gen;

  localparam int CW = 28;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    avs_s0_address = '0;
  logic          avs_s0_read = 1'b0;
  logic          avs_s0_write = 1'b0;
  logic [31:0]   avs_s0_readdata;
  logic [31:0]   avs_s0_writedata = '0;
  logic [CW-1:0] prescaller = '0;
  logic          tick;
  logic          irq;

  prescaled_tick_gen #(.CNT_W(CW), .TCNT_W(32)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .avs_s0_address   (avs_s0_address),
    .avs_s0_read      (avs_s0_read),
    .avs_s0_write     (avs_s0_write),
    .avs_s0_readdata  (avs_s0_readdata),
    .avs_s0_writedata (avs_s0_writedata),
    .prescaller       (prescaller),
    .tick             (tick),
    .irq              (irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic tick;
    logic irq;
  } exp_t;

  exp_t        out_q[$];
  logic [31:0] rd_q[$];
  int          checks = 0;
  int          errors = 0;

  bit          m_en, m_os, m_ie, m_pend, m_tick;
  int unsigned m_cyc, m_pstart, m_next;
  logic [31:0] m_tcnt;

  function automatic void model_reset();
    m_en = 0; m_os = 0; m_ie = 0; m_pend = 0; m_tick = 0;
    m_pstart = m_cyc; m_next = 0; m_tcnt = '0;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {29'd0, m_ie, m_os, m_en};
      2'd1:    return {30'd0, m_pend, m_en};
      2'd2:    return m_tcnt;
      default: return m_en ? 32'(m_cyc - m_pstart) : 32'd0;
    endcase
  endfunction

  // One clock edge in terms of event times: a tick lands on m_next.
  function automatic void model_edge(input bit w, input logic [1:0] a,
                                     input logic [31:0] d,
                                     input logic [CW-1:0] p);
    bit old_en;
    bit set;
    m_cyc++;
    old_en = m_en;
    m_tick = m_en && (m_cyc == m_next);
    set = m_tick && m_ie;
    if (w && a == 2'd1 && d[1]) m_pend = 0;
    if (set) m_pend = 1;
    if (m_tick) begin
      m_tcnt++;
      if (m_os) m_en = 0;
      m_pstart = m_cyc;
      m_next = m_cyc + p + 1;
    end
    if (w && a == 2'd2) m_tcnt = '0;
    if (w && a == 2'd0) begin
      if (d[0] && !old_en) begin
        m_pstart = m_cyc;
        m_next = m_cyc + p + 1;
      end
      m_en = d[0]; m_os = d[1]; m_ie = d[2];
    end
  endfunction

  task automatic step();
    exp_t e;
    @(posedge clk);
    #2;
    m_cyc = m_cyc;
    if (!reset_n) begin
      m_cyc++;
      model_reset();
    end else begin
      model_edge(avs_s0_write, avs_s0_address, avs_s0_writedata, prescaller);
    end
    e.tick = m_tick;
    e.irq = m_pend & m_ie;
    out_q.push_back(e);
  endtask

  task automatic drive(input bit w, input bit r, input logic [1:0] a,
                       input logic [31:0] d);
    avs_s0_write = w;
    avs_s0_read = r;
    avs_s0_address = a;
    avs_s0_writedata = d;
    if (r) rd_q.push_back(m_read(a));
  endtask

  task automatic cyc(input bit w, input bit r, input logic [1:0] a,
                     input logic [31:0] d);
    step();
    drive(w, r, a, d);
  endtask

  // Issue a write so that it lands on the next tick edge.
  task automatic write_on_tick(input logic [1:0] a, input logic [31:0] d);
    int n = 0;
    step();
    while (!(m_en && m_cyc + 1 == m_next) && n < 64) begin
      drive(0, 0, 2'd0, 0);
      step();
      n++;
    end
    checks++;
    if (n >= 64) begin
      errors++;
      $display("FAIL tick_wait: no tick within %0d cycles, need < 64", n);
    end
    drive(1, 0, a, d);
  endtask

  initial begin : monitor
    exp_t  e;
    logic [31:0] x;
    forever begin
      @(negedge clk);
      if (out_q.size() != 0) begin
        e = out_q.pop_front();
        checks++;
        if (tick !== e.tick || irq !== e.irq) begin
          errors++;
          $display("FAIL tick_irq t=%0t: got tick=%b irq=%b, need tick=%b irq=%b",
                   $time, tick, irq, e.tick, e.irq);
        end
      end
      checks++;
      if (avs_s0_read) begin
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL readq t=%0t: read with no expected value", $time);
        end else begin
          x = rd_q.pop_front();
          if (avs_s0_readdata !== x) begin
            errors++;
            $display("FAIL read a=%0d t=%0t: got %h, need %h",
                     avs_s0_address, $time, avs_s0_readdata, x);
          end
        end
      end else if (avs_s0_readdata !== 32'd0) begin
        errors++;
        $display("FAIL idle_rd t=%0t: got %h, need 0", $time, avs_s0_readdata);
      end
    end
  end

  initial begin : stim
    logic [31:0] d;
    logic [1:0]  a;
    m_cyc = 0;
    model_reset();
    prescaller = CW'(3);
    drive(0, 0, 2'd0, 0);
    repeat (3) cyc(0, 1, 2'd3, 0);
    step(); reset_n = 1'b1; drive(0, 1, 2'd0, 0);
    // periodic run, P=3
    cyc(1, 0, 2'd0, 32'h1);
    repeat (14) cyc(0, 1, 2'd3, 0);
    cyc(0, 1, 2'd2, 0);
    // P=0
    cyc(1, 0, 2'd0, 32'h0);
    prescaller = CW'(0);
    cyc(1, 0, 2'd0, 32'h1);
    repeat (5) cyc(0, 1, 2'd2, 0);
    // mid-period change 9 -> 2
    cyc(1, 0, 2'd0, 32'h0);
    prescaller = CW'(9);
    cyc(1, 0, 2'd0, 32'h1);
    repeat (4) cyc(0, 1, 2'd3, 0);
    prescaller = CW'(2);
    repeat (14) cyc(0, 1, 2'd3, 0);
    // oneshot with irq
    cyc(1, 0, 2'd0, 32'h0);
    cyc(1, 0, 2'd1, 32'h2);
    cyc(1, 0, 2'd2, 32'h0);
    prescaller = CW'(5);
    cyc(1, 0, 2'd0, 32'h7);
    repeat (8) cyc(0, 1, 2'd1, 0);
    cyc(1, 0, 2'd1, 32'h2);
    repeat (8) cyc(0, 1, 2'd2, 0);
    // collisions
    prescaller = CW'(3);
    cyc(1, 0, 2'd0, 32'h5);
    write_on_tick(2'd2, 32'h0);
    cyc(0, 1, 2'd2, 0);
    write_on_tick(2'd1, 32'h2);
    cyc(0, 1, 2'd1, 0);
    // tick counter wrap
    step();
    force dut.tick_count = 32'hFFFF_FFFF;
    #1 release dut.tick_count;
    m_tcnt = 32'hFFFF_FFFF;
    drive(0, 1, 2'd2, 0);
    repeat (6) cyc(0, 1, 2'd2, 0);
    // async reset while running with irq high
    step();
    reset_n = 1'b0;
    m_cyc = m_cyc;
    model_reset();
    out_q[out_q.size()-1] = '0;
    drive(0, 1, 2'd0, 0);
    cyc(0, 1, 2'd3, 0);
    step(); reset_n = 1'b1; drive(0, 1, 2'd1, 0);
    repeat (6) cyc(0, 1, 2'd3, 0);
    // randomized run
    repeat (3000) begin
      step();
      if ($urandom_range(0, 29) == 0) prescaller = CW'($urandom_range(0, 6));
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        a = 2'd0;
        d = {29'd0, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0)};
      end
      drive($urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)), a, d);
    end
    step();
    drive(0, 0, 2'd0, 0);
    @(negedge clk);
    #1;
    checks++;
    if (out_q.size() != 0 || rd_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d left, need 0/0",
               out_q.size(), rd_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
